muldiv_unit: RTL and testbench

// - Iterative 16-bit multiply/divide engine. It is the writer side of the HI/LO register pair.
// - Takes two operands from the datapath and computes the result over multiple cycles.
// - Presents the HI and LO words with a one-cycle write-enable pulse.
// - One write strobe drives both the HI and LO register instances. Those registers capture on negedge clk.

---
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative WIDTH-bit shift-add multiplier / restoring divider that writes the HI/LO pair.
// Optional signed mode: define MULDIV_SIGNED_EN.
module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             wehilo,
  output logic [WIDTH-1:0] hi_wd,
  output logic [WIDTH-1:0] lo_wd,
  output logic             div_zero
);

  localparam int         CW   = $clog2(WIDTH);
  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, WRITE} state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               dz_q, dz_d;

  logic [2*WIDTH-1:0] sum, prod;
  logic [WIDTH:0]     rpart, diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx, quo_nx, rem_fx, quo_fx, a_mag, b_mag;

`ifdef MULDIV_SIGNED_EN
  logic neg_q, neg_d, rneg_q, rneg_d;
`else
  logic unused_op1;
  assign unused_op1 = op[1];
`endif

  always_comb begin
    // Multiply step: add the multiplicand at the current bit weight.
    sum    = acc_q + (b_q[cnt_q[CW-1:0]] ? ((2*WIDTH)'(a_q) << cnt_q) : '0);
    // Divide step: acc low word is the partial remainder, a_q shifts dividend out / quotient in.
    rpart  = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
    diff   = rpart - {1'b0, b_q};
    ge     = ~diff[WIDTH];
    rem_nx = ge ? diff[WIDTH-1:0] : rpart[WIDTH-1:0];
    quo_nx = {a_q[WIDTH-2:0], ge};

    prod   = sum;
    rem_fx = rem_nx;
    quo_fx = quo_nx;
    a_mag  = a;
    b_mag  = b;
`ifdef MULDIV_SIGNED_EN
    neg_d  = neg_q;
    rneg_d = rneg_q;
    if (neg_q) begin
      prod   = -sum;
      quo_fx = -quo_nx;
    end
    if (rneg_q) rem_fx = -rem_nx;
    if (op[1] && a[WIDTH-1]) a_mag = -a;
    if (op[1] && b[WIDTH-1]) b_mag = -b;
`endif

    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = a_mag;
          b_d   = b_mag;
          cnt_d = '0;
          acc_d = '0;
          dz_d  = 1'b0;
`ifdef MULDIV_SIGNED_EN
          neg_d  = op[1] & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d = op[1] & a[WIDTH-1];
`endif
          if (!op[0]) begin
            state_d = MUL;
          end else if (b == '0) begin
            // Divide by zero reports the raw dividend regardless of signedness.
            state_d = WRITE;
            hi_d    = a;
            lo_d    = '1;
            dz_d    = 1'b1;
          end else begin
            state_d = DIV;
          end
        end
      end
      MUL: begin
        acc_d = sum;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          state_d = WRITE;
          hi_d    = prod[2*WIDTH-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
        end
      end
      DIV: begin
        acc_d = {{WIDTH{1'b0}}, rem_nx};
        a_d   = quo_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          state_d = WRITE;
          hi_d    = rem_fx;
          lo_d    = quo_fx;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
`ifdef MULDIV_SIGNED_EN
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == WRITE);
  assign wehilo   = (state_q == WRITE);
  assign hi_wd    = hi_q;
  assign lo_wd    = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus directed literal cases and random traffic.
module tb_muldiv_unit;

  logic        clk, rst_n, start;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic        busy, done, wehilo, div_zero;
  logic [15:0] hi_wd, lo_wd;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  // Model state: cycles until idle (0 = idle, 1 = write cycle) and expected register contents.
  int          m_left = 0;
  logic [15:0] m_hi   = '0;
  logic [15:0] m_lo   = '0;
  logic        m_dz   = 1'b0;
  logic [31:0] m_pend = '0;

  muldiv_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .wehilo(wehilo),
    .hi_wd(hi_wd), .lo_wd(lo_wd), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp_v);
    end
  endtask

  // Returns {hi, lo} for a completed operation.
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    logic        sg;
    int          sx, sy, q, r;
    logic [31:0] t, u;
    sg = 1'b0;
`ifdef MULDIV_SIGNED_EN
    sg = o[1];
`endif
    sx = $signed(x);
    sy = $signed(y);
    if (!o[0]) begin
      if (sg) t = sx * sy;
      else    t = {16'h0, x} * {16'h0, y};
      return t;
    end
    if (y == 16'h0) return {x, 16'hFFFF};
    if (sg) begin
      q = sx / sy;
      r = sx % sy;
      t = q;
      u = r;
      return {u[15:0], t[15:0]};
    end
    return {x % y, x / y};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_hi = '0; m_lo = '0; m_dz = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        m_pend = ref_res(op, a, b);
        if (op[0] && b == 16'h0) begin
          m_left = 1;
          m_hi   = m_pend[31:16];
          m_lo   = m_pend[15:0];
          m_dz   = 1'b1;
        end else begin
          m_left = 17;
          m_dz   = 1'b0;
        end
      end
    end else begin
      if (m_left == 2) begin
        m_hi = m_pend[31:16];
        m_lo = m_pend[15:0];
      end
      m_left = m_left - 1;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_left != 0);
    chk("wehilo", wehilo, m_left == 1);
    chk("done", done, m_left == 1);
    chk("hi_wd", hi_wd, m_hi);
    chk("lo_wd", lo_wd, m_lo);
    chk("div_zero", div_zero, m_dz);
    if (wehilo) we_cnt++;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic do_op(input string nm, input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] eh, input logic [15:0] el, input logic ed, input int elat);
    int n;
    int w0;
    wait_idle();
    w0 = we_cnt;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!wehilo && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, n, elat);
    chk({nm, "_hi"}, hi_wd, eh);
    chk({nm, "_lo"}, lo_wd, el);
    chk({nm, "_dz"}, div_zero, ed);
    chk({nm, "_done"}, done, 1'b1);
    @(negedge clk);
    chk({nm, "_pulses"}, we_cnt - w0, 1);
    chk({nm, "_hold_hi"}, hi_wd, eh);
  endtask

  initial begin
    int w0;
    rst_n = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_wehilo", wehilo, 1'b0);
    chk("rst_hi", hi_wd, 16'h0);
    chk("rst_lo", lo_wd, 16'h0);
    chk("rst_dz", div_zero, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("mul1",  2'b00, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0, 17);
    do_op("mul2",  2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17);
    do_op("div1",  2'b01, 16'd100,  16'd7,    16'h0002, 16'h000E, 1'b0, 17);
    do_op("divz",  2'b01, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1);

    // A start pulse in cycle 5 of a multiply must be dropped.
    wait_idle();
    w0 = we_cnt;
    start = 1'b1; op = 2'b00; a = 16'd3; b = 16'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b01; a = 16'd9; b = 16'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("ign_pulses", we_cnt - w0, 1);
    chk("ign_hi", hi_wd, 16'h0000);
    chk("ign_lo", lo_wd, 16'h000F);
    chk("ign_dz", div_zero, 1'b0);

    // Reset in cycle 8 of a divide aborts it with no write.
    wait_idle();
    w0 = we_cnt;
    start = 1'b1; op = 2'b01; a = 16'd1000; b = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_wehilo", wehilo, 1'b0);
    chk("abort_hi", hi_wd, 16'h0);
    chk("abort_lo", lo_wd, 16'h0);
    chk("abort_dz", div_zero, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_pulses", we_cnt - w0, 0);
    do_op("div2",  2'b01, 16'd1000, 16'd3,    16'h0001, 16'h014D, 1'b0, 17);

`ifdef MULDIV_SIGNED_EN
    do_op("smul",  2'b10, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 1'b0, 17);
    do_op("sdiv",  2'b11, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, 17);
    do_op("sdivc", 2'b11, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 17);
    do_op("sdivz", 2'b11, 16'h8000, 16'h0000, 16'h8000, 16'hFFFF, 1'b1, 1);
`else
    do_op("umul",  2'b10, 16'hFFFD, 16'h0005, 16'h0004, 16'hFFF1, 1'b0, 17);
    do_op("udiv",  2'b11, 16'hFFF9, 16'h0002, 16'h0001, 16'h7FFC, 1'b0, 17);
`endif

    // Random traffic, including starts while busy and zero divisors.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom);
      a     = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'h0000;
        1:       b = 16'hFFFF;
        default: b = 16'($urandom);
      endcase
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
